// File: rtl/background_tile_fetcher.sv
// rtl/background_tile_fetcher.sv - background tile fetch sequencer and loopy v register; optional BG_GARBAGE_NT_FETCH_EN
module background_tile_fetcher (
    input  logic        clock,
    input  logic        reset,
    input  logic        clock_EN,
    input  logic        renderEnable,
    input  logic [8:0]  dot,
    input  logic [8:0]  scanline,
    input  logic [14:0] tReg,
    input  logic        vLoad,
    input  logic        bgPatternSel,
    input  logic [7:0]  vramData,
    output logic [13:0] vramAddr,
    output logic        vramRead,
    output logic [7:0]  tileHighByte,
    output logic [7:0]  tileLowByte,
    output logic [1:0]  tileAttr,
    output logic        loadOut,
    output logic [14:0] vOut
);

    logic [14:0] v_q, v_d, v_inc;
    logic [13:0] vram_addr_q, vram_addr_d;
    logic        vram_read_q, vram_read_d;
    logic [7:0]  tile_idx_q;
    logic [7:0]  pt_low_q;
    logic [7:0]  tile_hi_q, tile_lo_q;
    logic [1:0]  at_shift_q, at_bits_q, tile_attr_q;
    logic [1:0]  at_sel;
    logic        load_q;
    logic        started_q;

    logic        render_line;
    logic        fetch_dot;
    logic        fetch_active;
    logic [2:0]  phase;
    logic [13:0] nt_addr, at_addr, pt_addr_lo, pt_addr_hi;

    // Fetch window decode and address formation from the current v
    always_comb begin
        render_line  = (scanline <= 9'd239) || (scanline == 9'd261);
        fetch_dot    = ((dot >= 9'd1) && (dot <= 9'd256)) || ((dot >= 9'd321) && (dot <= 9'd336));
        fetch_active = renderEnable && render_line && fetch_dot;
        phase        = dot[2:0];
        nt_addr      = {2'b10, v_q[11:0]};
        at_addr      = {2'b10, v_q[11:10], 4'b1111, v_q[9:7], v_q[4:2]};
        pt_addr_lo   = {1'b0, bgPatternSel, tile_idx_q, 1'b0, v_q[14:12]};
        pt_addr_hi   = {1'b0, bgPatternSel, tile_idx_q, 1'b1, v_q[14:12]};
    end

    // Address/strobe for the next edge: only odd phases inside the window issue reads
    always_comb begin
        vram_addr_d = '0;
        vram_read_d = 1'b0;
        if (fetch_active && phase[0]) begin
            vram_read_d = 1'b1;
            case (phase)
                3'd1:    vram_addr_d = nt_addr;
                3'd3:    vram_addr_d = at_addr;
                3'd5:    vram_addr_d = pt_addr_lo;
                default: vram_addr_d = pt_addr_hi;
            endcase
        end
`ifdef BG_GARBAGE_NT_FETCH_EN
        else if (renderEnable && render_line && ((dot == 9'd337) || (dot == 9'd339))) begin
            // Dummy NT reads some mappers count on; the data is never latched
            vram_read_d = 1'b1;
            vram_addr_d = nt_addr;
        end
`endif
    end

    // Attribute quadrant select using the shift captured at the AT address phase
    always_comb begin
        case (at_shift_q)
            2'd0:    at_sel = vramData[1:0];
            2'd1:    at_sel = vramData[3:2];
            2'd2:    at_sel = vramData[5:4];
            default: at_sel = vramData[7:6];
        endcase
    end

    // Scroll increments and t->v copies; a vLoad overrides everything on that edge
    always_comb begin
        v_inc = v_q;
        if (fetch_active && (phase == 3'd0)) begin
            if (v_q[4:0] == 5'd31) begin
                v_inc[4:0] = 5'd0;
                v_inc[10]  = ~v_q[10];
            end else begin
                v_inc[4:0] = v_q[4:0] + 5'd1;
            end
        end
        if (renderEnable && render_line && (dot == 9'd256)) begin
            if (v_q[14:12] != 3'd7) begin
                v_inc[14:12] = v_q[14:12] + 3'd1;
            end else begin
                v_inc[14:12] = 3'd0;
                if (v_q[9:5] == 5'd29) begin
                    v_inc[9:5] = 5'd0;
                    v_inc[11]  = ~v_q[11];
                end else if (v_q[9:5] == 5'd31) begin
                    // Coarse Y parked in the attribute rows wraps without a nametable flip
                    v_inc[9:5] = 5'd0;
                end else begin
                    v_inc[9:5] = v_q[9:5] + 5'd1;
                end
            end
        end
        if (renderEnable && render_line && (dot == 9'd257)) begin
            v_inc[10]  = tReg[10];
            v_inc[4:0] = tReg[4:0];
        end
        if (renderEnable && (scanline == 9'd261) && (dot >= 9'd280) && (dot <= 9'd304)) begin
            v_inc[14:11] = tReg[14:11];
            v_inc[9:5]   = tReg[9:5];
        end
        v_d = v_q;
        if (clock_EN) begin
            v_d = v_inc;
        end
        if (vLoad) begin
            v_d = tReg;
        end
    end

    // Fetch sequencer: latches per phase; a tile is only emitted if its NT phase was seen
    always_ff @(posedge clock) begin
        if (reset) begin
            v_q         <= '0;
            vram_addr_q <= '0;
            vram_read_q <= 1'b0;
            tile_idx_q  <= '0;
            pt_low_q    <= '0;
            tile_hi_q   <= '0;
            tile_lo_q   <= '0;
            at_shift_q  <= '0;
            at_bits_q   <= '0;
            tile_attr_q <= '0;
            load_q      <= 1'b0;
            started_q   <= 1'b0;
        end else begin
            load_q <= 1'b0;
            v_q    <= v_d;
            if (clock_EN) begin
                vram_addr_q <= vram_addr_d;
                vram_read_q <= vram_read_d;
                if (!fetch_active) begin
                    started_q <= 1'b0;
                end else begin
                    case (phase)
                        3'd1: started_q <= 1'b1;
                        3'd2: if (started_q) tile_idx_q <= vramData;
                        3'd3: at_shift_q <= {v_q[6], v_q[1]};
                        3'd4: if (started_q) at_bits_q <= at_sel;
                        3'd6: if (started_q) pt_low_q <= vramData;
                        3'd0: begin
                            if (started_q) begin
                                tile_hi_q   <= vramData;
                                tile_lo_q   <= pt_low_q;
                                tile_attr_q <= at_bits_q;
                                load_q      <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign vramAddr     = vram_addr_q;
    assign vramRead     = vram_read_q;
    assign tileHighByte = tile_hi_q;
    assign tileLowByte  = tile_lo_q;
    assign tileAttr     = tile_attr_q;
    assign loadOut      = load_q;
    assign vOut         = v_q;

endmodule

// File: tb/tb_background_tile_fetcher.sv
// tb/tb_background_tile_fetcher.sv - self-checking bench for background_tile_fetcher
module tb_background_tile_fetcher;
    logic        clock = 1'b0;
    logic        reset;
    logic        clock_EN;
    logic        renderEnable;
    logic [8:0]  dot;
    logic [8:0]  scanline;
    logic [14:0] tReg;
    logic        vLoad;
    logic        bgPatternSel;
    logic [7:0]  vramData;
    logic [13:0] vramAddr;
    logic        vramRead;
    logic [7:0]  tileHighByte;
    logic [7:0]  tileLowByte;
    logic [1:0]  tileAttr;
    logic        loadOut;
    logic [14:0] vOut;

    logic [7:0] mem [0:16383];
    int total = 0;
    int bad = 0;

    // model state: scroll fields as plain integers, pending tile, held outputs
    int cx, cy, fy, nh, nv;
    bit m_started;
    logic [7:0] m_nt, m_lo, m_hi, o_hi, o_lo;
    logic [1:0] m_at, o_at;

    background_tile_fetcher dut (
        .clock(clock), .reset(reset), .clock_EN(clock_EN), .renderEnable(renderEnable),
        .dot(dot), .scanline(scanline), .tReg(tReg), .vLoad(vLoad), .bgPatternSel(bgPatternSel),
        .vramData(vramData), .vramAddr(vramAddr), .vramRead(vramRead),
        .tileHighByte(tileHighByte), .tileLowByte(tileLowByte), .tileAttr(tileAttr),
        .loadOut(loadOut), .vOut(vOut)
    );

    always #5 clock = ~clock;
    assign vramData = mem[vramAddr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s dot=%0d sl=%0d observed=%0h expected=%0h", tag, dot, scanline, obs, exp);
        end
    endtask

    function automatic logic [14:0] model_v();
        return 15'(fy * 4096 + nv * 2048 + nh * 1024 + cy * 32 + cx);
    endfunction

    function automatic logic [13:0] nt_addr_of();
        return 14'(8192 + (nv * 2 + nh) * 1024 + cy * 32 + cx);
    endfunction

    function automatic logic [13:0] at_addr_of();
        return 14'(8192 + 960 + (nv * 2 + nh) * 1024 + (cy / 4) * 8 + cx / 4);
    endfunction

    function automatic logic [13:0] pt_addr_of(input int plane);
        return 14'((bgPatternSel ? 4096 : 0) + int'(m_nt) * 16 + plane * 8 + fy);
    endfunction

    task automatic model_from_t(input logic [14:0] t);
        cx = int'(t[4:0]);
        cy = int'(t[9:5]);
        nh = int'(t[10]);
        nv = int'(t[11]);
        fy = int'(t[14:12]);
    endtask

    task automatic model_reset();
        cx = 0; cy = 0; fy = 0; nh = 0; nv = 0;
        m_started = 1'b0;
        m_nt = '0; m_lo = '0; m_hi = '0; m_at = '0;
        o_hi = '0; o_lo = '0; o_at = '0;
    endtask

    task automatic check_zero();
        chk("zero_vOut", vOut, 15'h0);
        chk("zero_vramAddr", vramAddr, 14'h0);
        chk("zero_vramRead", vramRead, 1'b0);
        chk("zero_tileHigh", tileHighByte, 8'h0);
        chk("zero_tileLow", tileLowByte, 8'h0);
        chk("zero_tileAttr", tileAttr, 2'b00);
        chk("zero_loadOut", loadOut, 1'b0);
    endtask

    // one enabled dot: predict, clock, compare every output
    task automatic step(input int d, input int sl, input bit re, input bit vl, input logic [14:0] t);
        bit line, win, fetch, exp_read, exp_load;
        int ph, s;
        logic [13:0] exp_addr;
        logic [7:0] atb;
        dot = 9'(d);
        scanline = 9'(sl);
        renderEnable = re;
        vLoad = vl;
        tReg = t;
        clock_EN = 1'b1;
        reset = 1'b0;
        line  = (sl <= 239) || (sl == 261);
        win   = (d >= 1 && d <= 256) || (d >= 321 && d <= 336);
        fetch = re && line && win;
        ph    = d % 8;
        if (fetch && ph == 1) begin
            m_nt = mem[nt_addr_of()];
            atb  = mem[at_addr_of()];
            s    = 2 * ((cy / 2) % 2) + (cx / 2) % 2;
            m_at = 2'((atb >> (2 * s)) & 8'h03);
            m_lo = mem[pt_addr_of(0)];
            m_hi = mem[pt_addr_of(1)];
            m_started = 1'b1;
        end
        exp_read = fetch && (ph % 2 == 1);
        exp_addr = '0;
        if (exp_read) begin
            case (ph)
                1: exp_addr = nt_addr_of();
                3: exp_addr = at_addr_of();
                5: exp_addr = pt_addr_of(0);
                default: exp_addr = pt_addr_of(1);
            endcase
        end
`ifdef BG_GARBAGE_NT_FETCH_EN
        if (re && line && (d == 337 || d == 339)) begin
            exp_read = 1'b1;
            exp_addr = nt_addr_of();
        end
`endif
        exp_load = fetch && (ph == 0) && m_started;
        if (exp_load) begin
            o_hi = m_hi; o_lo = m_lo; o_at = m_at;
        end
        if (!fetch) m_started = 1'b0;
        if (vl) begin
            model_from_t(t);
        end else if (re && line) begin
            if (fetch && ph == 0) begin
                cx++;
                if (cx == 32) begin cx = 0; nh ^= 1; end
            end
            if (d == 256) begin
                if (fy < 7) fy++;
                else begin
                    fy = 0;
                    if (cy == 29) begin cy = 0; nv ^= 1; end
                    else if (cy == 31) cy = 0;
                    else cy++;
                end
            end
            if (d == 257) begin
                cx = int'(t[4:0]);
                nh = int'(t[10]);
            end
            if (sl == 261 && d >= 280 && d <= 304) begin
                fy = int'(t[14:12]);
                nv = int'(t[11]);
                cy = int'(t[9:5]);
            end
        end
        @(posedge clock);
        #1;
        vLoad = 1'b0;
        chk("vramRead", vramRead, exp_read);
        chk("vramAddr", vramAddr, exp_addr);
        chk("loadOut", loadOut, exp_load);
        chk("tileHigh", tileHighByte, o_hi);
        chk("tileLow", tileLowByte, o_lo);
        chk("tileAttr", tileAttr, o_at);
        chk("vOut", vOut, model_v());
    endtask

    initial begin
        int sl_list[5];
        int reads;
        bit re, vl, outside;
        logic [14:0] vsave;
        for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
        mem[14'h2000] = 8'h24;
        mem[14'h23C0] = 8'hE4;
        reset = 1'b1; clock_EN = 1'b1; renderEnable = 1'b0; vLoad = 1'b0;
        bgPatternSel = 1'b0; tReg = '0; dot = '0; scanline = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_zero();
        reset = 1'b0;

        // scanline 0 from t=0 with NT byte 0x24
        step(0, 0, 1'b1, 1'b1, 15'h0000);
        step(1, 0, 1'b1, 1'b0, 15'h0);
        chk("first_nt_addr", vramAddr, 14'h2000);
        chk("first_nt_read", vramRead, 1'b1);
        step(2, 0, 1'b1, 1'b0, 15'h0);
        chk("latch_no_read", vramRead, 1'b0);
        chk("latch_addr_zero", vramAddr, 14'h0);
        step(3, 0, 1'b1, 1'b0, 15'h0);
        chk("first_at_addr", vramAddr, 14'h23C0);
        step(4, 0, 1'b1, 1'b0, 15'h0);
        step(5, 0, 1'b1, 1'b0, 15'h0);
        chk("first_ptlo_addr", vramAddr, 14'h0240);
        step(6, 0, 1'b1, 1'b0, 15'h0);
        step(7, 0, 1'b1, 1'b0, 15'h0);
        chk("first_pthi_addr", vramAddr, 14'h0248);
        for (int d = 8; d <= 340; d++) step(d, 0, 1'b1, 1'b0, 15'h0);

        // attribute quadrant select: v[6]=1, v[1]=0 on AT byte 0xE4
        step(0, 1, 1'b1, 1'b1, 15'h0040);
        for (int d = 1; d <= 7; d++) step(d, 1, 1'b1, 1'b0, 15'h0);
        chk("attr_no_early_load", loadOut, 1'b0);
        step(8, 1, 1'b1, 1'b0, 15'h0);
        chk("attr_load_dot8", loadOut, 1'b1);
        chk("attr_value", tileAttr, 2'b10);
        step(9, 1, 1'b1, 1'b0, 15'h0);
        chk("attr_load_one_cycle", loadOut, 1'b0);

        // coarse X wrap toggles horizontal nametable
        step(0, 2, 1'b1, 1'b1, 15'h001F);
        for (int d = 1; d <= 8; d++) step(d, 2, 1'b1, 1'b0, 15'h0);
        chk("cx_wrap_zero", vOut[4:0], 5'd0);
        chk("cx_wrap_nt", vOut[10], 1'b1);

        // fine/coarse Y wraps at dot 256
        step(0, 10, 1'b1, 1'b1, {3'd7, 2'b00, 5'd29, 5'd3});
        step(256, 10, 1'b1, 1'b0, 15'h0);
        chk("y29_fine", vOut[14:12], 3'd0);
        chk("y29_coarse", vOut[9:5], 5'd0);
        chk("y29_nt_toggle", vOut[11], 1'b1);
        step(0, 11, 1'b1, 1'b1, {3'd7, 2'b00, 5'd31, 5'd3});
        step(256, 11, 1'b1, 1'b0, 15'h0);
        chk("y31_coarse", vOut[9:5], 5'd0);
        chk("y31_nt_kept", vOut[11], 1'b0);

        // rendering off for a whole scanline, then a vLoad
        vsave = model_v();
        reads = 0;
        for (int d = 0; d <= 340; d++) begin
            step(d, 3, 1'b0, 1'b0, 15'($urandom));
            reads += int'(vramRead);
        end
        chk("off_no_reads", reads, 0);
        chk("off_v_held", vOut, vsave);
        step(0, 3, 1'b0, 1'b1, 15'h1234);
        chk("off_vload", vOut, 15'h1234);

        // randomized scanlines incl. pre-render, last visible and post-render
        sl_list = '{261, 0, 120, 239, 240};
        for (int k = 0; k < 5; k++) begin
            bgPatternSel = 1'($urandom);
            re = (sl_list[k] == 120) ? 1'($urandom) : 1'b1;
            for (int d = 0; d <= 340; d++) begin
                outside = !((d >= 1 && d <= 256) || (d >= 321 && d <= 336));
                vl = outside && ($urandom_range(0, 19) == 0);
                step(d, sl_list[k], re, vl, 15'($urandom));
            end
        end

        // reset mid-tile with clock_EN low; next tile emitted at dot 16
        step(0, 5, 1'b1, 1'b1, 15'h0000);
        for (int d = 1; d <= 3; d++) step(d, 5, 1'b1, 1'b0, 15'h0);
        reset = 1'b1;
        clock_EN = 1'b0;
        dot = 9'd4;
        @(posedge clock);
        #1;
        check_zero();
        model_reset();
        reset = 1'b0;
        for (int d = 5; d <= 16; d++) begin
            step(d, 5, 1'b1, 1'b0, 15'h0);
            if (d == 8)  chk("rst_no_load_dot8", loadOut, 1'b0);
            if (d == 16) chk("rst_load_dot16", loadOut, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
